// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq_pkg
// Description : Shared ALU op-code encoding, FSM state codes and op-class
//               helpers for the multi-cycle RV32M sequencer. The same
//               package provides the alu_ctr encoding for the main ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_seq_pkg;

    localparam int ALUCTR_W = 5;

    // ALU op-code encoding; the M-extension occupies 5'b01010..5'b10001
    localparam logic [ALUCTR_W-1:0] ALU_ADD    = 5'b00000;
    localparam logic [ALUCTR_W-1:0] ALU_SUB    = 5'b00001;
    localparam logic [ALUCTR_W-1:0] ALU_SLL    = 5'b00010;
    localparam logic [ALUCTR_W-1:0] ALU_SLT    = 5'b00011;
    localparam logic [ALUCTR_W-1:0] ALU_SLTU   = 5'b00100;
    localparam logic [ALUCTR_W-1:0] ALU_XOR    = 5'b00101;
    localparam logic [ALUCTR_W-1:0] ALU_SRL    = 5'b00110;
    localparam logic [ALUCTR_W-1:0] ALU_SRA    = 5'b00111;
    localparam logic [ALUCTR_W-1:0] ALU_OR     = 5'b01000;
    localparam logic [ALUCTR_W-1:0] ALU_AND    = 5'b01001;
    localparam logic [ALUCTR_W-1:0] ALU_MUL    = 5'b01010;
    localparam logic [ALUCTR_W-1:0] ALU_MULH   = 5'b01011;
    localparam logic [ALUCTR_W-1:0] ALU_MULHSU = 5'b01100;
    localparam logic [ALUCTR_W-1:0] ALU_MULHU  = 5'b01101;
    localparam logic [ALUCTR_W-1:0] ALU_DIV    = 5'b01110;
    localparam logic [ALUCTR_W-1:0] ALU_DIVU   = 5'b01111;
    localparam logic [ALUCTR_W-1:0] ALU_REM    = 5'b10000;
    localparam logic [ALUCTR_W-1:0] ALU_REMU   = 5'b10001;

    // Sequencer state codes
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic logic is_div(input logic [ALUCTR_W-1:0] ctr);
        return (ctr >= ALU_DIV) && (ctr <= ALU_REMU);
    endfunction

    function automatic logic is_sdiv(input logic [ALUCTR_W-1:0] ctr);
        return (ctr == ALU_DIV) || (ctr == ALU_REM);
    endfunction

    function automatic logic is_rem(input logic [ALUCTR_W-1:0] ctr);
        return (ctr == ALU_REM) || (ctr == ALU_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq_if
// Description : Request/response bundle between the EX stage (master) and
//               the multiply/divide sequencer (slave).
//               in_*  : op request (valid/ready, ctr, op1, op2, rd tag)
//               out_* : result (valid/ready, data, rd tag); busy = not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_seq_if #(
    parameter int ALUCTR_WIDTH = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_WIDTH    = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ALUCTR_WIDTH-1:0] in_ctr;
    logic [DATA_WIDTH-1:0]   in_op1;
    logic [DATA_WIDTH-1:0]   in_op2;
    logic [TAG_WIDTH-1:0]    in_rd;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [TAG_WIDTH-1:0]    out_rd;
    logic                    busy;

    modport master (
        output in_valid, in_ctr, in_op1, in_op2, in_rd, out_ready,
        input  in_ready, out_valid, out_data, out_rd, busy
    );

    modport slave (
        input  in_valid, in_ctr, in_op1, in_op2, in_rd, out_ready,
        output in_ready, out_valid, out_data, out_rd, busy
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq_div_core.sv
`default_nettype none
// ============================================================================
// Module      : div_core
// Description : Unsigned radix-2 restoring divider, one quotient bit per
//               step. start loads operands; DATA_WIDTH steps follow.
//   clk, rst_n           : clock, async active-low reset
//   start, step          : load operands / perform one iteration
//   dividend, divisor    : unsigned operands sampled on start
//   quotient, remainder  : running (final after last) results
//   last                 : current step is the final iteration
// Revision    : 1.0 - initial release
// ============================================================================
module div_core #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic                  step,
    input  wire logic [DATA_WIDTH-1:0] dividend,
    input  wire logic [DATA_WIDTH-1:0] divisor,
    output logic      [DATA_WIDTH-1:0] quotient,
    output logic      [DATA_WIDTH-1:0] remainder,
    output logic                       last
);
    localparam int                CNT_W   = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] quo_q, rem_q, dsr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH:0]   w_trial;
    logic                  w_fits;

    // Partial remainder shifted left with the next dividend bit; top bit
    // of the difference is the borrow (divisor did not fit).
    assign w_trial = {rem_q, quo_q[DATA_WIDTH-1]} - {1'b0, dsr_q};
    assign w_fits  = ~w_trial[DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
            cnt_q <= CNT_MAX;
        end else if (step) begin
            if (w_fits) begin
                rem_q <= w_trial[DATA_WIDTH-1:0];
            end else begin
                rem_q <= {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]};
            end
            // Dividend bits shift out the top while quotient bits fill in
            quo_q <= {quo_q[DATA_WIDTH-2:0], w_fits};
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = step && (cnt_q == '0);
endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Multi-cycle RV32M sequencer beside the EX-stage ALU.
//               MUL-class: one registered stage. DIV/REM: iterative divider
//               followed by a sign-fix cycle. RISC-V divide-by-zero and
//               signed overflow resolve at accept.
//   clk, rst_n : clock, async active-low reset
//   flush      : drop any in-flight op, return to IDLE
//   bus        : request/response bundle (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int ALUCTR_WIDTH = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_WIDTH    = 5
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   flush,
    muldiv_seq_if.slave bus
);
    localparam logic [DATA_WIDTH-1:0] C_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [2:0]              state_q, state_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [ALUCTR_WIDTH-1:0] ctr_q;
    logic [DATA_WIDTH-1:0]   op1_q, op2_q;
    logic [TAG_WIDTH-1:0]    rd_q;

    logic                    w_accept, w_div_start, w_div_last;
    logic                    w_in_sdiv, w_in_rem, w_special;
    logic [DATA_WIDTH-1:0]   w_special_res, w_dividend, w_divisor;
    logic [DATA_WIDTH-1:0]   w_quo, w_rem, w_fix_res, w_mul_res;
    logic                    w_sx1, w_sx2, w_q_neg, w_r_neg;
    logic [2*DATA_WIDTH-1:0] w_prod;

    assign w_accept = bus.in_valid && (state_q == ST_IDLE) && !flush;

    // ---- request-side decode (only meaningful in IDLE) --------------------
    assign w_in_sdiv = is_sdiv(bus.in_ctr);
    assign w_in_rem  = is_rem(bus.in_ctr);
    assign w_special = (bus.in_op2 == '0) ||
                       (w_in_sdiv && bus.in_op1 == C_MIN && bus.in_op2 == '1);
    // Zero divisor: quotient all ones, remainder = dividend.
    // Signed overflow: quotient = dividend (MIN), remainder 0.
    assign w_special_res = (bus.in_op2 == '0) ? (w_in_rem ? bus.in_op1 : '1)
                                              : (w_in_rem ? '0 : bus.in_op1);

    // Magnitudes for the unsigned core; -MIN wraps to MIN, which is the
    // correct unsigned magnitude.
    assign w_dividend = (w_in_sdiv && bus.in_op1[DATA_WIDTH-1]) ? -bus.in_op1 : bus.in_op1;
    assign w_divisor  = (w_in_sdiv && bus.in_op2[DATA_WIDTH-1]) ? -bus.in_op2 : bus.in_op2;

    div_core #(.DATA_WIDTH(DATA_WIDTH)) u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_div_start),
        .step      (state_q == ST_DIV),
        .dividend  (w_dividend),
        .divisor   (w_divisor),
        .quotient  (w_quo),
        .remainder (w_rem),
        .last      (w_div_last)
    );

    // ---- multiply: operands extended to full product width ----------------
    assign w_sx1  = op1_q[DATA_WIDTH-1] && (ctr_q == ALU_MULH || ctr_q == ALU_MULHSU);
    assign w_sx2  = op2_q[DATA_WIDTH-1] && (ctr_q == ALU_MULH);
    assign w_prod = {{DATA_WIDTH{w_sx1}}, op1_q} * {{DATA_WIDTH{w_sx2}}, op2_q};

    always_comb begin
        case (ctr_q)
            ALU_MUL:                       w_mul_res = w_prod[DATA_WIDTH-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: w_mul_res = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            default:                       w_mul_res = '0;   // non-M op codes
        endcase
    end

    // ---- divide sign fix ---------------------------------------------------
    assign w_q_neg   = is_sdiv(ctr_q) && (op1_q[DATA_WIDTH-1] ^ op2_q[DATA_WIDTH-1]);
    assign w_r_neg   = is_sdiv(ctr_q) && op1_q[DATA_WIDTH-1];
    assign w_fix_res = is_rem(ctr_q) ? (w_r_neg ? -w_rem : w_rem)
                                     : (w_q_neg ? -w_quo : w_quo);

    // ---- sequencer ---------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        w_div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (is_div(bus.in_ctr)) begin
                        if (w_special) begin
                            state_d    = ST_DONE;
                            out_data_d = w_special_res;
                        end else begin
                            state_d     = ST_DIV;
                            w_div_start = 1'b1;
                        end
                    end else begin
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                out_data_d = w_mul_res;
                state_d    = ST_DONE;
            end
            ST_DIV: begin
                if (w_div_last) state_d = ST_FIX;
            end
            ST_FIX: begin
                out_data_d = w_fix_res;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d    = ST_IDLE;
            out_data_d = out_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            out_data_q <= '0;
            ctr_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            if (w_accept) begin
                ctr_q <= bus.in_ctr;
                op1_q <= bus.in_op1;
                op2_q <= bus.in_op2;
                rd_q  <= bus.in_rd;
            end
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_data  = out_data_q;
    assign bus.out_rd    = rd_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Directed self-checking bench for muldiv_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    muldiv_seq_if #(.ALUCTR_WIDTH(5), .DATA_WIDTH(32), .TAG_WIDTH(5)) bus ();

    muldiv_seq #(.ALUCTR_WIDTH(5), .DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge (E0), then drop in_valid
    task automatic issue(input logic [4:0] ctr, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        bus.in_ctr   = ctr;
        bus.in_op1   = a;
        bus.in_op2   = b;
        bus.in_rd    = rd;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Edges after E0 until out_valid; counts cycles where busy was low
    task automatic wait_valid(output int lat, output int busy_low);
        lat      = 0;
        busy_low = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            if (bus.busy !== 1'b1) busy_low++;
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [4:0] ctr, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_lat);
        int lat, busy_low;
        issue(ctr, a, b, rd);
        wait_valid(lat, busy_low);
        check({tag, ".lat"},      lat,          exp_lat);
        check({tag, ".busy"},     busy_low,     0);
        check({tag, ".data"},     bus.out_data, exp);
        check({tag, ".rd"},       bus.out_rd,   {27'd0, rd});
        consume();
        check({tag, ".in_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        bus.in_valid  = 1'b0;
        bus.in_ctr    = '0;
        bus.in_op1    = '0;
        bus.in_op2    = '0;
        bus.in_rd     = '0;
        bus.out_ready = 1'b0;

        // Reset
        #1 rst_n = 1'b0;
        #11;
        check("rst.out_valid", bus.out_valid, 0);
        check("rst.out_data",  bus.out_data,  0);
        check("rst.out_rd",    bus.out_rd,    0);
        check("rst.busy",      bus.busy,      0);
        #10 rst_n = 1'b1;
        tick();
        check("rst.in_ready", bus.in_ready, 1);

        // Multiply family: latency 1 edge after E0
        run("mul",    ALU_MUL,    32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 1);
        run("mulhu",  ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 1);
        run("mulh",   ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000000, 1);
        run("mulhsu", ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 1);
        run("add",    ALU_ADD,    32'd12,       32'd30,       5'd7,  32'h00000000, 1);

        // Iterative divide: 33 edges after E0
        run("div",  ALU_DIV,  32'hFFFFFFF9, 32'd2, 5'd8,  32'hFFFFFFFD, 33);
        run("rem",  ALU_REM,  32'hFFFFFFF9, 32'd2, 5'd9,  32'hFFFFFFFF, 33);
        run("divu", ALU_DIVU, 32'd100,      32'd7, 5'd10, 32'd14,       33);

        // Special cases resolved at accept
        run("divu0", ALU_DIVU, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 0);
        run("remu0", ALU_REMU, 32'd5,        32'd0,        5'd12, 32'd5,        0);
        run("divov", ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 0);
        run("remov", ALU_REM,  32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        0);

        // Hold result with out_ready low; new requests must be ignored
        issue(ALU_MUL, 32'd7, 32'hFFFFFFFD, 5'd9);
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.in_ctr   = ALU_DIVU;
            bus.in_op1   = 32'd1000 + i;
            bus.in_op2   = 32'd3;
            bus.in_rd    = 5'd20 + 5'(i);
            bus.in_valid = 1'b1;
            tick();
            check("hold.out_valid", bus.out_valid, 1);
            check("hold.out_data",  bus.out_data,  32'hFFFFFFEB);
            check("hold.out_rd",    bus.out_rd,    32'd9);
            check("hold.in_ready",  bus.in_ready,  0);
        end
        bus.in_valid = 1'b0;
        consume();
        check("hold.idle", bus.busy, 0);

        // Flush during divide iteration 10
        issue(ALU_DIVU, 32'd100, 32'd7, 5'd15);
        for (int i = 0; i < 10; i++) tick();
        check("flush.pre_busy", bus.busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush.busy",      bus.busy,      0);
        check("flush.out_valid", bus.out_valid, 0);
        check("flush.in_ready",  bus.in_ready,  1);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid !== 1'b0) vcount++;
            tick();
        end
        check("flush.no_result", vcount, 0);
        run("div_after_flush", ALU_DIVU, 32'd100, 32'd7, 5'd16, 32'd14, 33);

        // Async reset in the middle of a multiply
        issue(ALU_MUL, 32'd7, 32'hFFFFFFFD, 5'd17);
        check("arst.pre_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst.out_data",  bus.out_data,  0);
        check("arst.out_rd",    bus.out_rd,    0);
        check("arst.busy",      bus.busy,      0);
        check("arst.out_valid", bus.out_valid, 0);
        #1 rst_n = 1'b1;
        tick();
        check("arst.in_ready", bus.in_ready, 1);
        check("arst.no_valid", bus.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
